// File: rtl/ysyx_25040111_marbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, error types (also used by
// the csr mcause mapping) and LSU size codes.
package ysyx_25040111_marbiter_pkg;

    typedef enum logic [1:0] {
        MARB_IDLE  = 2'd0,
        MARB_BUSY  = 2'd1,
        MARB_DRAIN = 2'd2
    } marb_state_e;

    typedef enum logic [3:0] {
        ERR_NONE    = 4'h0,
        ERR_BUS     = 4'h1,
        ERR_TIMEOUT = 4'h2
    } err_type_e;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'd0,
        MASK_HALF = 2'd1,
        MASK_WORD = 2'd2
    } mask_size_e;

endpackage

// File: rtl/ysyx_25040111_marbiter_rrpick.sv
// Combinational winner picker. Scans from the channel after `last`, wrapping
// around; with rr_en low the scan always starts at ch0 (fixed priority).
module ysyx_25040111_marbiter_rrpick #(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    input  logic                   rr_en,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] index,
    output logic                   any
);
    localparam int IW = $clog2(NCH);

    logic [IW-1:0] base;
    logic [IW-1:0] cand;

    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        base  = rr_en ? last : IW'(NCH - 1);
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IW'((int'(base) + k) % NCH);
            if (!any && req[cand]) begin
                any         = 1'b1;
                index       = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_25040111_marbiter.sv
// N-channel memory arbiter in front of the single LSU port: fixed/round-robin
// grant, burst beat counting, drain-safe flush and a per-beat timeout watchdog.
module ysyx_25040111_marbiter
    import ysyx_25040111_marbiter_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LENW = 8,
    parameter int RR   = 1,
    parameter int TMO  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [NCH-1:0]         req_valid,
    input  logic [NCH-1:0]         req_write,
    input  logic [NCH*AW-1:0]      req_addr,
    input  logic [NCH*DW-1:0]      req_wdata,
    input  logic [NCH*2-1:0]       req_mask,
    input  logic [NCH-1:0]         req_rsign,
    input  logic [NCH*LENW-1:0]    req_len,
    output logic [NCH-1:0]         rsp_valid,
    output logic [DW-1:0]          rsp_data,
    output logic                   rsp_last,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_write,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [1:0]             mem_mask,
    output logic                   mem_rsign,
    output logic [LENW-1:0]        mem_len,
    output logic                   mem_burst,
    input  logic [DW-1:0]          mem_rdata,
    input  logic                   mem_err,
    output logic                   err,
    output logic [3:0]             err_tp,
    output logic [$clog2(NCH)-1:0] err_ch
);
    localparam int IW = $clog2(NCH);
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    marb_state_e    state;
    logic [IW-1:0]  owner;
    logic [NCH-1:0] owner_oh;
    logic [IW-1:0]  last_ptr;
    logic [LENW:0]  beat_cnt;   // one extra bit so len = 2^LENW-1 cannot wrap
    logic [TW-1:0]  tmo_cnt;

    logic [NCH-1:0] pick_grant;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic           pick_write;
    logic [LENW-1:0] pick_len;

    ysyx_25040111_marbiter_rrpick #(.NCH(NCH)) u_pick (
        .req   (req_valid),
        .last  (last_ptr),
        .rr_en (RR != 0),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign pick_write = req_write[pick_idx];
    assign pick_len   = req_len[pick_idx*LENW +: LENW];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= MARB_IDLE;
            owner     <= '0;
            owner_oh  <= '0;
            last_ptr  <= IW'(NCH - 1);
            beat_cnt  <= '0;
            tmo_cnt   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            mem_rsign <= 1'b0;
            mem_len   <= '0;
            mem_burst <= 1'b0;
            err       <= 1'b0;
            err_tp    <= '0;
            err_ch    <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_last  <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                MARB_IDLE: begin
                    if (pick_any && !flush) begin
                        owner     <= pick_idx;
                        owner_oh  <= pick_grant;
                        last_ptr  <= pick_idx;
                        mem_write <= pick_write;
                        mem_addr  <= req_addr[pick_idx*AW +: AW];
                        mem_wdata <= req_wdata[pick_idx*DW +: DW];
                        mem_mask  <= req_mask[pick_idx*2 +: 2];
                        mem_rsign <= req_rsign[pick_idx];
                        mem_len   <= pick_write ? '0 : pick_len;
                        mem_burst <= !pick_write && (pick_len != '0);
                        mem_valid <= 1'b1;
                        beat_cnt  <= '0;
                        tmo_cnt   <= '0;
                        state     <= MARB_BUSY;
                    end
                end
                MARB_BUSY: begin
                    if (flush) begin
                        // A beat completing with the flush is already done on the LSU side.
                        if (mem_ready) begin
                            mem_valid <= 1'b0;
                            state     <= MARB_IDLE;
                        end else begin
                            state <= MARB_DRAIN;
                        end
                    end else if (mem_ready) begin
                        tmo_cnt   <= '0;
                        rsp_valid <= owner_oh;
                        rsp_data  <= mem_rdata;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (mem_err) begin
                            rsp_last  <= 1'b1;
                            err       <= 1'b1;
                            err_tp    <= ERR_BUS;
                            err_ch    <= owner;
                            mem_valid <= 1'b0;
                            state     <= MARB_IDLE;
                        end else if (beat_cnt == {1'b0, mem_len}) begin
                            rsp_last  <= 1'b1;
                            mem_valid <= 1'b0;
                            state     <= MARB_IDLE;
                        end
                    end else if (TMO != 0 && tmo_cnt == TMO_LAST) begin
                        rsp_valid <= owner_oh;
                        rsp_last  <= 1'b1;
                        err       <= 1'b1;
                        err_tp    <= ERR_TIMEOUT;
                        err_ch    <= owner;
                        mem_valid <= 1'b0;
                        state     <= MARB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                MARB_DRAIN: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= MARB_IDLE;
                    end
                end
                default: state <= MARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_25040111_marbiter.md
Name: ysyx_25040111_marbiter

Overview:
- Parametrised N-channel memory arbiter. It sits between the core's memory requesters (icache refill, EXU load/store, future dcache/DMA) and the single LSU port.
- Generalises the fixed two-master arbiter to NCH channels.
- Adds selectable fixed-priority or round-robin arbitration, burst beat counting, a flush that drains safely, and a per-beat timeout watchdog that reports errors.

Parameters:
- NCH, 2, number of requester channels (2..8)
- AW, 32, address width
- DW, 32, data width
- LENW, 8, burst length field width (beats = len+1)
- RR, 1, 0 = fixed priority (ch0 highest), 1 = round-robin
- TMO, 0, beat timeout in cycles; 0 disables the watchdog

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  abort pending responses (pipeline flush)
- req_valid  in  NCH  per-channel request
- req_write  in  NCH  1 = write, 0 = read
- req_addr  in  NCH*AW  packed addresses, channel i at [i*AW +: AW]
- req_wdata  in  NCH*DW  packed write data
- req_mask  in  NCH*2  size code: 0 = byte, 1 = half, 2 = word
- req_rsign  in  NCH  sign-extend read
- req_len  in  NCH*LENW  burst length minus 1; reads only
- rsp_valid  out  NCH  one-cycle pulse per completed beat to the owner channel
- rsp_data  out  DW  beat read data, shared bus
- rsp_last  out  1  final beat of the transaction
- mem_valid  out  1  request to LSU
- mem_ready  in  1  one-cycle beat completion from LSU
- mem_write, mem_addr, mem_wdata, mem_mask, mem_rsign, mem_len, mem_burst  out  1/AW/DW/2/1/LENW/1  latched request fields
- mem_rdata  in  DW  beat read data
- mem_err  in  1  bus error with beat
- err  out  1  one-cycle error pulse
- err_tp  out  4  error type
- err_ch  out  $clog2(NCH)  faulting channel

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer last = NCH-1, so ch0 wins first; beat and timeout counters 0.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - if any req_valid: pick winner g and latch all of channel g's fields into registers.
  - mem_valid=1 from the next cycle; go to BUSY. Arbitration latency is 1 cycle.
  - mem_burst = !write && len != 0.
  - Writes force mem_len = 0.
- Picking rule:
  - RR = 0: lowest index wins.
  - RR = 1: first requesting index after last, wrapping modulo NCH. Update last = g on grant.
- BUSY:
  - mem_valid stays 1 and latched fields are stable until the final beat.
  - On each mem_ready: the next cycle brings rsp_valid[g]=1 and rsp_data = registered mem_rdata; the beat counter increments.
  - On the beat where count == len: rsp_last=1 with that pulse; mem_valid drops in the same cycle as the registered response; return to IDLE.
  - A new grant may issue the cycle after return, so back-to-back transactions have 1 idle cycle.
- mem_err with mem_ready:
  - terminate immediately: rsp_valid[g] and rsp_last pulse next cycle.
  - err=1, err_tp=4'h1 (BUS), err_ch=g; return to IDLE.
  - Remaining beats are not requested.
- Timeout (TMO > 0):
  - counter resets on every mem_ready and counts while BUSY.
  - on reaching TMO: err=1, err_tp=4'h2 (TIMEOUT), err_ch=g, rsp_last pulse to g, mem_valid drops, go to IDLE.
- flush in BUSY:
  - go to DRAIN. mem_valid stays high until the current beat's mem_ready, because an LSU beat cannot be cancelled.
  - No rsp_valid is emitted in DRAIN or for the draining beat.
  - Then go to IDLE. Remaining burst beats are abandoned.
- flush in IDLE: that cycle's grant is suppressed.
- flush in DRAIN: no effect.
- Requester obligation: hold req_valid and fields until its rsp_last. Early deassert does not abort; responses still pulse.
- Simultaneous mem_ready and timeout expiry: mem_ready wins and the timeout is ignored.
- Simultaneous flush and final mem_ready in BUSY: flush wins and the response is suppressed.
- reset mid-transaction: immediate return to reset values; the LSU is reset by the same signal.
- Beat counter width is LENW+1, so no wrap at len = 2^LENW-1.

Decomposition:
- Shared header ysyx_25040111_inc.vh holds:
  - state encodings MARB_IDLE/BUSY/DRAIN
  - error type codes ERR_BUS=4'h1 and ERR_TIMEOUT=4'h2, shared with csr mcause mapping
  - mask size codes
- Sub-module ysyx_25040111_rrpick: combinational, parametrised NCH. Inputs req, last, rr_en; outputs onehot grant, index, any.

Test Plan:
- NCH=2, RR=1: ch0 and ch1 both request continuously with single-beat reads and mem_ready 2 cycles after mem_valid.
  - grants alternate 0,1,0,1; each rsp_valid has rsp_last=1.
- NCH=4, RR=0: ch3 requests at t0, ch1 at t0+1.
  - ch3 is granted first; ch1 is granted the cycle after ch3's rsp_last.
- ch0 read burst, len=3, mem_rdata 0x11,0x22,0x33,0x44.
  - four rsp_valid[0] pulses with that data; rsp_last only on 0x44; mem_len=3, mem_burst=1.
- ch1 write with req_len=5.
  - mem_len=0, mem_burst=0; a single rsp_valid[1] with rsp_last.
- len=3 burst with mem_err on beat 2.
  - err=1, err_tp=1, err_ch=owner; exactly 2 responses; IDLE next cycle.
- TMO=8 with mem_ready never asserted.
  - err_tp=2 exactly 8 cycles after mem_valid rises; mem_valid=0 after.
- flush in BUSY mid-burst.
  - mem_valid held until the next mem_ready; zero rsp_valid; IDLE; next requester granted.
